// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle: D/EX instruction info in, stall/flush controls out.
interface hazard_ctrl_if;
  logic [4:0] D_rs1;
  logic [4:0] D_rs2;
  logic       D_use_rs1;
  logic       D_use_rs2;
  logic [4:0] EX_rd;
  logic       EX_ld;
  logic       EX_mul;
  logic       EX_taken;
  logic       stall_F;
  logic       stall_D;
  logic       flush_D;
  logic       mul_busy;
  logic       mul_done;

  modport master (
    output D_rs1, D_rs2, D_use_rs1, D_use_rs2, EX_rd, EX_ld, EX_mul, EX_taken,
    input  stall_F, stall_D, flush_D, mul_busy, mul_done
  );

  modport slave (
    input  D_rs1, D_rs2, D_use_rs1, D_use_rs2, EX_rd, EX_ld, EX_mul, EX_taken,
    output stall_F, stall_D, flush_D, mul_busy, mul_done
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stall, multi-cycle multiply wait, taken-branch flush.
// Optional HAZARD_PERF_EN adds stall-cycle and flush-cycle performance counters.
module hazard_ctrl #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
`ifdef HAZARD_PERF_EN
  hazard_ctrl_if.slave      bus,
  output logic [31:0]       perf_stall_cyc,
  output logic [31:0]       perf_flush_cnt
`else
  hazard_ctrl_if.slave      bus
`endif
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MUL_WAIT = 1'b1
  } state_t;

  localparam logic [3:0] MUL_WAIT_CYC = 4'(MUL_LAT - 1);
  localparam bit         MUL_HAS_WAIT = (MUL_LAT > 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       w_lu;
  logic       w_rs1_hit;
  logic       w_rs2_hit;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign w_rs1_hit = bus.D_use_rs1 && (bus.D_rs1 == bus.EX_rd);
  assign w_rs2_hit = bus.D_use_rs2 && (bus.D_rs2 == bus.EX_rd);
  assign w_lu      = bus.EX_ld && (bus.EX_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);

  // Next-state and control-output decode
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    bus.stall_F  = 1'b0;
    bus.stall_D  = 1'b0;
    bus.flush_D  = 1'b0;
    bus.mul_busy = 1'b0;
    bus.mul_done = 1'b0;
    if (rst) begin
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = 4'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.EX_taken) begin
            bus.flush_D = 1'b1;
          end else if (w_lu) begin
            bus.stall_F = 1'b1;
            bus.stall_D = 1'b1;
          end else begin
            bus.flush_D = 1'b0;
          end
          if (bus.EX_mul && MUL_HAS_WAIT) begin
            w_state_nxt = ST_MUL_WAIT;
            w_cnt_nxt   = MUL_WAIT_CYC;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_MUL_WAIT: begin
          // EX holds a bubble here, so EX_* inputs are deliberately not looked at
          bus.stall_F  = 1'b1;
          bus.stall_D  = 1'b1;
          bus.mul_busy = 1'b1;
          w_cnt_nxt    = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            bus.mul_done = 1'b1;
            w_state_nxt  = ST_RUN;
          end else if (r_cnt == 4'd0) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_state_nxt = ST_MUL_WAIT;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  // State and wait-counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  // Event counters; natural 32-bit wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= 32'd0;
      r_perf_flush <= 32'd0;
    end else begin
      r_perf_stall <= r_perf_stall + {31'd0, bus.stall_D};
      r_perf_flush <= r_perf_flush + {31'd0, bus.flush_D};
    end
  end

  assign perf_stall_cyc = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios followed by randomized traffic.
module tb_hazard_ctrl;
  localparam int unsigned MUL_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if bus_if ();

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cyc;
  logic [31:0] perf_flush_cnt;
  hazard_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus_if.slave),
    .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
  );
`else
  hazard_ctrl #(.MUL_LAT(MUL_LAT)) dut (.clk(clk), .rst(rst), .bus(bus_if.slave));
`endif

  typedef struct {
    int          cyc;
    logic        sf;
    logic        sd;
    logic        fl;
    logic        busy;
    logic        done;
    logic [31:0] ps;
    logic [31:0] pf;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: a multiply accepted in cycle t occupies cycles t+1 .. t+MUL_LAT-1
  int          cyc_idx  = 0;
  int          mul_last = -1;
  logic [31:0] m_stall  = 32'd0;
  logic [31:0] m_flush  = 32'd0;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, c, act, req);
    end
  endtask

  task automatic cyc(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] rd,
                     input logic ld, input logic mul, input logic tk);
    exp_t e;
    bit   hazard;
    @(posedge clk);
    #1;
    rst              = r;
    bus_if.D_rs1     = rs1;
    bus_if.D_rs2     = rs2;
    bus_if.D_use_rs1 = u1;
    bus_if.D_use_rs2 = u2;
    bus_if.EX_rd     = rd;
    bus_if.EX_ld     = ld;
    bus_if.EX_mul    = mul;
    bus_if.EX_taken  = tk;
    e = '{cyc: cyc_idx, sf: 1'b0, sd: 1'b0, fl: 1'b0, busy: 1'b0, done: 1'b0,
          ps: m_stall, pf: m_flush};
    if (r) begin
      mul_last = -1;
      m_stall  = 32'd0;
      m_flush  = 32'd0;
    end else if (cyc_idx <= mul_last) begin
      e.sf = 1'b1; e.sd = 1'b1; e.busy = 1'b1;
      e.done = (cyc_idx == mul_last);
    end else begin
      hazard = ld && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      e.fl = tk;
      e.sf = !tk && hazard;
      e.sd = !tk && hazard;
      if (mul && MUL_LAT > 1) mul_last = cyc_idx + int'(MUL_LAT) - 1;
    end
    if (!r) begin
      m_stall = m_stall + {31'd0, e.sd};
      m_flush = m_flush + {31'd0, e.fl};
    end
    q.push_back(e);
    cyc_idx++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares every presented cycle against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall_F",  e.cyc, {31'd0, bus_if.stall_F},  {31'd0, e.sf});
        chk("stall_D",  e.cyc, {31'd0, bus_if.stall_D},  {31'd0, e.sd});
        chk("flush_D",  e.cyc, {31'd0, bus_if.flush_D},  {31'd0, e.fl});
        chk("mul_busy", e.cyc, {31'd0, bus_if.mul_busy}, {31'd0, e.busy});
        chk("mul_done", e.cyc, {31'd0, bus_if.mul_done}, {31'd0, e.done});
`ifdef HAZARD_PERF_EN
        chk("perf_stall_cyc", e.cyc, perf_stall_cyc, e.ps);
        chk("perf_flush_cnt", e.cyc, perf_flush_cnt, e.pf);
`endif
      end
    end
  end

  initial begin
    int op;
    int budget;
    bus_if.D_rs1 = 5'd0; bus_if.D_rs2 = 5'd0; bus_if.D_use_rs1 = 1'b0; bus_if.D_use_rs2 = 1'b0;
    bus_if.EX_rd = 5'd0; bus_if.EX_ld = 1'b0; bus_if.EX_mul = 1'b0; bus_if.EX_taken = 1'b0;

    // reset held for a few cycles, with busy-looking inputs to show outputs are forced low
    cyc(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle(1);
    // load-use on rs1, then bubble in EX
    cyc(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    // x0 destination and unused operand: no hazard
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    // rs2 hazard
    cyc(1'b0, 5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    // hazard masked by taken branch
    cyc(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
    // multiply, full wait, then back-to-back multiply
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
    idle(3);
    // reset on the final wait cycle kills mul_done
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
    idle(1);
    cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(2);

    for (int i = 0; i < 600; i++) begin
      op = int'($urandom_range(0, 5));
      cyc(($urandom_range(0, 39) == 0),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
          (op == 0), (op == 1), (op == 2));
    end
    idle(1);

    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (q.size() > 0) chk("scoreboard_drain", cyc_idx, 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
